// File: rtl/axi_aw_credit_slice_pkg.sv
// Shared AW-channel types for the credit slice: payload struct, bus widths and
// helpers that gather/scatter the individual AW fields.
package axi_aw_credit_slice_pkg;

  localparam int BUS_ID_W = 4;
  localparam int PADDR    = 32;

  typedef struct packed {
    logic [BUS_ID_W-1:0] awid;
    logic [PADDR-1:0]    awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
  } axi_aw_payload_t;

  function automatic axi_aw_payload_t pack_aw(
    input logic [BUS_ID_W-1:0] id,
    input logic [PADDR-1:0]    addr,
    input logic [7:0]          len,
    input logic [2:0]          size,
    input logic [1:0]          burst,
    input logic                lock,
    input logic [3:0]          cache,
    input logic [2:0]          prot,
    input logic [3:0]          qos,
    input logic [3:0]          region
  );
    axi_aw_payload_t p;
    p.awid     = id;
    p.awaddr   = addr;
    p.awlen    = len;
    p.awsize   = size;
    p.awburst  = burst;
    p.awlock   = lock;
    p.awcache  = cache;
    p.awprot   = prot;
    p.awqos    = qos;
    p.awregion = region;
    return p;
  endfunction

  function automatic void unpack_aw(
    input  axi_aw_payload_t     p,
    output logic [BUS_ID_W-1:0] id,
    output logic [PADDR-1:0]    addr,
    output logic [7:0]          len,
    output logic [2:0]          size,
    output logic [1:0]          burst,
    output logic                lock,
    output logic [3:0]          cache,
    output logic [2:0]          prot,
    output logic [3:0]          qos,
    output logic [3:0]          region
  );
    id     = p.awid;
    addr   = p.awaddr;
    len    = p.awlen;
    size   = p.awsize;
    burst  = p.awburst;
    lock   = p.awlock;
    cache  = p.awcache;
    prot   = p.awprot;
    qos    = p.awqos;
    region = p.awregion;
  endfunction

endpackage

// File: rtl/axi_aw.sv
// AXI write-address channel bundle. A beat transfers on a cycle where
// awvalid && awready; the master holds awvalid and the payload stable until then.
interface axi_aw;
  import axi_aw_credit_slice_pkg::*;

  logic                awvalid;
  logic                awready;
  logic [BUS_ID_W-1:0] awid;
  logic [PADDR-1:0]    awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [3:0]          awregion;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache,
           awprot, awqos, awregion,
    input  awready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache,
           awprot, awqos, awregion,
    output awready
  );
endinterface

// File: rtl/axi_skid_buffer.sv
// Two-entry skid buffer with a registered upstream ready; acc_en_i gates the
// ready for the next cycle so an external credit counter can throttle intake.
module axi_skid_buffer #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic arst_n,
  input  logic s_valid_i,
  output logic s_ready_o,
  input  T     s_data_i,
  input  logic acc_en_i,
  output logic m_valid_o,
  input  logic m_ready_i,
  output T     m_data_o,
  output logic acc_o,
  output logic out_valid_o,
  output logic skid_valid_o
);

  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic rdy_q, rdy_d;
  logic snd;
  T     out_data_q, out_data_d;
  T     skid_data_q, skid_data_d;

  assign acc_o = s_valid_i & rdy_q;
  assign snd   = out_valid_q & m_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q) begin
      if (acc_o) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data_i;
      end
    end else if (snd) begin
      // Ready was low whenever the skid is full, so acc cannot collide here.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc_o) begin
        out_data_d = s_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc_o) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end

  assign rdy_d = !skid_valid_d && acc_en_i;

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign s_ready_o    = rdy_q;
  assign m_valid_o    = out_valid_q;
  assign m_data_o     = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/axi_aw_credit_slice.sv
// Registered AW slice that caps accepted-but-unresponded writes at
// MAX_OUTSTANDING and reports idle/underflow for fence logic.
module axi_aw_credit_slice
  import axi_aw_credit_slice_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             arst_n,
  axi_aw.slave             s_aw,
  axi_aw.master            m_aw,
  input  logic             b_hs_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             idle_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  axi_aw_payload_t  in_pl;
  axi_aw_payload_t  out_pl;
  logic             acc, dec, acc_en;
  logic             m_valid, s_ready;
  logic             out_valid, skid_valid;
  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;

  assign in_pl = pack_aw(s_aw.awid, s_aw.awaddr, s_aw.awlen, s_aw.awsize,
                         s_aw.awburst, s_aw.awlock, s_aw.awcache, s_aw.awprot,
                         s_aw.awqos, s_aw.awregion);

  axi_skid_buffer #(.T(axi_aw_payload_t)) u_skid (
    .clk_i        (clk_i),
    .arst_n       (arst_n),
    .s_valid_i    (s_aw.awvalid),
    .s_ready_o    (s_ready),
    .s_data_i     (in_pl),
    .acc_en_i     (acc_en),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_aw.awready),
    .m_data_o     (out_pl),
    .acc_o        (acc),
    .out_valid_o  (out_valid),
    .skid_valid_o (skid_valid)
  );

  // A credit is taken at upstream acceptance, not at downstream send.
  always_comb begin
    dec         = b_hs_i & (count_q != '0);
    count_d     = count_q + CNT_W'(acc) - CNT_W'(dec);
    underflow_d = underflow_q | (b_hs_i & (count_q == '0));
  end

  assign acc_en = (count_d < MAX_CNT);

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign s_aw.awready  = s_ready;
  assign m_aw.awvalid  = m_valid;
  assign m_aw.awid     = out_pl.awid;
  assign m_aw.awaddr   = out_pl.awaddr;
  assign m_aw.awlen    = out_pl.awlen;
  assign m_aw.awsize   = out_pl.awsize;
  assign m_aw.awburst  = out_pl.awburst;
  assign m_aw.awlock   = out_pl.awlock;
  assign m_aw.awcache  = out_pl.awcache;
  assign m_aw.awprot   = out_pl.awprot;
  assign m_aw.awqos    = out_pl.awqos;
  assign m_aw.awregion = out_pl.awregion;

  assign outstanding_o = count_q;
  assign idle_o        = !out_valid && !skid_valid && (count_q == '0);
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_axi_aw_credit_slice.sv
// Bench for axi_aw_credit_slice: directed scenarios plus a random run, checked
// against a queue/counter model of the slice's transfer and credit rules.
module tb_axi_aw_credit_slice;
  import axi_aw_credit_slice_pkg::*;

  localparam int MAX_OUT = 4;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);
  localparam int PL_W    = $bits(axi_aw_payload_t);

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk_i = ~clk_i;

  logic             b_hs_i = 1'b0;
  logic [CNT_W-1:0] outstanding_o;
  logic             idle_o;
  logic             underflow_o;

  axi_aw s_aw ();
  axi_aw m_aw ();

  axi_aw_credit_slice #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i         (clk_i),
    .arst_n        (arst_n),
    .s_aw          (s_aw),
    .m_aw          (m_aw),
    .b_hs_i        (b_hs_i),
    .outstanding_o (outstanding_o),
    .idle_o        (idle_o),
    .underflow_o   (underflow_o)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [PL_W-1:0] exp_q[$];   // accepted, not yet sent, oldest first
  axi_aw_payload_t src_q[$];   // beats the upstream driver still has to offer
  int  m_cnt;                  // writes accepted and not yet answered on B
  bit  m_uf;
  bit  m_first;                // first cycle after reset release
  int  unresp;                 // sent and still waiting for a B pulse
  bit  b_auto, b_rand, snd_last;
  int  pass_cnt, fail_cnt, total_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic axi_aw_payload_t obs_pl();
    axi_aw_payload_t p;
    p.awid     = m_aw.awid;
    p.awaddr   = m_aw.awaddr;
    p.awlen    = m_aw.awlen;
    p.awsize   = m_aw.awsize;
    p.awburst  = m_aw.awburst;
    p.awlock   = m_aw.awlock;
    p.awcache  = m_aw.awcache;
    p.awprot   = m_aw.awprot;
    p.awqos    = m_aw.awqos;
    p.awregion = m_aw.awregion;
    return p;
  endfunction

  function automatic axi_aw_payload_t rand_pl();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PL_W-1:0];
  endfunction

  function automatic axi_aw_payload_t mk_pl(input int id, input logic [31:0] addr);
    axi_aw_payload_t p;
    p          = '0;
    p.awid     = id[BUS_ID_W-1:0];
    p.awaddr   = addr;
    p.awlen    = 8'(id + 1);
    p.awsize   = 3'd3;
    p.awburst  = 2'd1;
    p.awcache  = 4'(id);
    p.awqos    = 4'hA;
    p.awregion = 4'(15 - id);
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_src();
    if (src_q.size() > 0) begin
      s_aw.awvalid  = 1'b1;
      s_aw.awid     = src_q[0].awid;
      s_aw.awaddr   = src_q[0].awaddr;
      s_aw.awlen    = src_q[0].awlen;
      s_aw.awsize   = src_q[0].awsize;
      s_aw.awburst  = src_q[0].awburst;
      s_aw.awlock   = src_q[0].awlock;
      s_aw.awcache  = src_q[0].awcache;
      s_aw.awprot   = src_q[0].awprot;
      s_aw.awqos    = src_q[0].awqos;
      s_aw.awregion = src_q[0].awregion;
    end else begin
      s_aw.awvalid = 1'b0;
    end
  endtask

  // One clock: check outputs against the model, then advance the model by the
  // handshakes that happen at the coming rising edge. Called at a falling edge.
  task automatic cycle();
    bit exp_rdy, acc, snd, dec;
    if (b_auto) b_hs_i = snd_last;
    else if (b_rand) b_hs_i = (unresp > 0) && ($urandom_range(0, 2) == 0);
    drive_src();
    exp_rdy = !m_first && (exp_q.size() < 2) && (m_cnt < MAX_OUT);
    chk("awready", s_aw.awready, exp_rdy);
    chk("awvalid", m_aw.awvalid, exp_q.size() > 0);
    if (exp_q.size() > 0) chk("payload", obs_pl(), exp_q[0]);
    chk("outstanding", outstanding_o, m_cnt);
    chk("idle", idle_o, (exp_q.size() == 0) && (m_cnt == 0));
    chk("underflow", underflow_o, m_uf);
    acc = s_aw.awvalid && exp_rdy;
    snd = (exp_q.size() > 0) && m_aw.awready;
    dec = b_hs_i && (m_cnt > 0);
    if (b_hs_i && m_cnt == 0) m_uf = 1'b1;
    if (b_hs_i && unresp > 0) unresp--;
    if (snd) begin
      void'(exp_q.pop_front());
      unresp++;
    end
    if (acc) exp_q.push_back(src_q.pop_front());
    m_cnt    = m_cnt + int'(acc) - int'(dec);
    m_first  = 1'b0;
    snd_last = snd;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Asserted at a falling edge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    chk("rst_awvalid", m_aw.awvalid, 1'b0);
    chk("rst_payload", obs_pl(), '0);
    chk("rst_awready", s_aw.awready, 1'b0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_underflow", underflow_o, 1'b0);
    @(negedge clk_i);
    arst_n = 1'b1;
    exp_q.delete();
    src_q.delete();
    m_cnt    = 0;
    m_uf     = 1'b0;
    m_first  = 1'b1;
    unresp   = 0;
    snd_last = 1'b0;
    b_auto   = 1'b0;
    b_rand   = 1'b0;
    b_hs_i   = 1'b0;
    s_aw.awvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_snd, first_snd, last_snd, max_out;
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    s_aw.awvalid = 1'b0;
    m_aw.awready = 1'b0;
    @(negedge clk_i);

    // Back-to-back stream with B answering one cycle after each send.
    do_reset();
    b_auto = 1'b1;
    m_aw.awready = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(mk_pl(i, 32'h1000 + 32'h40 * i));
    n_snd = 0; first_snd = -1; last_snd = -1; max_out = 0;
    for (int c = 0; c < 14; c++) begin
      if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);
      if (m_aw.awvalid && m_aw.awready) begin
        n_snd++;
        if (first_snd < 0) first_snd = c;
        last_snd = c;
      end
      cycle();
    end
    chk("t1_sends", n_snd, 8);
    chk("t1_first_send", first_snd, 2);
    chk("t1_last_send", last_snd, 9);
    chk("t1_max_outstanding", max_out, 2);
    chk("t1_idle_end", idle_o, 1'b1);

    // Credit limit: six offered, no B responses.
    do_reset();
    m_aw.awready = 1'b1;
    for (int i = 0; i < 6; i++) src_q.push_back(rand_pl());
    repeat (10) cycle();
    chk("t2_cnt_full", outstanding_o, MAX_OUT);
    chk("t2_rdy_low", s_aw.awready, 1'b0);
    b_hs_i = 1'b1;
    cycle();
    b_hs_i = 1'b0;
    chk("t2_rdy_back", s_aw.awready, 1'b1);
    chk("t2_cnt_dec", outstanding_o, MAX_OUT - 1);
    cycle();
    chk("t2_cnt_refill", outstanding_o, MAX_OUT);
    chk("t2_rdy_low_again", s_aw.awready, 1'b0);

    // Downstream stall fills the skid entry.
    do_reset();
    m_aw.awready = 1'b0;
    src_q.push_back(mk_pl(3, 32'h2000));
    src_q.push_back(mk_pl(4, 32'h2040));
    repeat (5) cycle();
    chk("t3_rdy_low", s_aw.awready, 1'b0);
    chk("t3_hold_valid", m_aw.awvalid, 1'b1);
    chk("t3_hold_id", m_aw.awid, 3);
    m_aw.awready = 1'b1;
    cycle();
    chk("t3_second_id", m_aw.awid, 4);
    chk("t3_rdy_back", s_aw.awready, 1'b1);
    cycle();
    chk("t3_drained", m_aw.awvalid, 1'b0);

    // Same-cycle accept and B leave the count unchanged.
    do_reset();
    m_aw.awready = 1'b1;
    src_q.push_back(rand_pl());
    src_q.push_back(rand_pl());
    repeat (5) cycle();
    chk("t4_cnt2", outstanding_o, 2);
    src_q.push_back(rand_pl());
    b_hs_i = 1'b1;
    cycle();
    b_hs_i = 1'b0;
    chk("t4_same_cycle", outstanding_o, 2);
    repeat (2) cycle();
    b_hs_i = 1'b1;
    cycle();
    b_hs_i = 1'b0;
    chk("t4_b_only", outstanding_o, 1);

    // B with nothing outstanding raises the sticky underflow flag.
    do_reset();
    repeat (2) cycle();
    b_hs_i = 1'b1;
    cycle();
    b_hs_i = 1'b0;
    chk("t5_underflow", underflow_o, 1'b1);
    chk("t5_cnt_zero", outstanding_o, 0);
    repeat (3) cycle();
    chk("t5_sticky", underflow_o, 1'b1);

    // Reset with two buffered beats and three credits in use.
    do_reset();
    m_aw.awready = 1'b1;
    src_q.push_back(rand_pl());
    repeat (3) cycle();
    m_aw.awready = 1'b0;
    src_q.push_back(rand_pl());
    src_q.push_back(rand_pl());
    repeat (4) cycle();
    chk("t6_cnt3", outstanding_o, 3);
    chk("t6_buffered", m_aw.awvalid, 1'b1);
    do_reset();
    chk("t6_rdy_first", s_aw.awready, 1'b0);
    cycle();
    chk("t6_rdy_second", s_aw.awready, 1'b1);

    // Random traffic, stalls and B timing.
    do_reset();
    b_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (src_q.size() == 0 && $urandom_range(0, 3) != 0)
        repeat ($urandom_range(1, 4)) src_q.push_back(rand_pl());
      m_aw.awready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_aw_credit_slice.md
Name: axi_aw_credit_slice

Overview:
- Registered AXI write-address channel slice between the core's write-address source and the memory-side AW consumer.
- Two-entry skid buffer gives full throughput with every downstream AW signal driven from flops.
- Limits in-flight write transactions to MAX_OUTSTANDING by reserving a credit on upstream acceptance and releasing it on each downstream B-channel handshake.
- Reports idle (no buffered AW, no outstanding write) for fence/flush logic.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unresponded write transactions; legal range 1..255.
- CNT_W, $clog2(MAX_OUTSTANDING+1), credit counter width; derived, not overridden.

Ports:
- clk_i  input  1  core clock.
- arst_n  input  1  asynchronous active-low reset.
- s_aw  axi_aw.slave  bundle  upstream AW channel; all fields pass through unmodified.
- m_aw  axi_aw.master  bundle  downstream AW channel.
- b_hs_i  input  1  downstream B handshake (bvalid & bready), one pulse per completed write.
- outstanding_o  output  CNT_W  current credit count in use.
- idle_o  output  1  no buffered AW and outstanding_o == 0.
- underflow_o  output  1  sticky error: b_hs_i seen with outstanding_o == 0.

Behaviour:
- Reset (arst_n low, asynchronous):
  - m_aw.awvalid = 0 and all m_aw payload fields = 0.
  - s_aw.awready = 0; out/skid valid = 0; count = 0; underflow_o = 0.
- Storage:
  - out register drives m_aw directly; skid register holds one extra beat.
  - Payload is all AW fields except valid/ready: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion.
- s_aw.awready is a registered flag: rdy_q <= !skid_valid_next && (count_next < MAX_OUTSTANDING).
  - It is therefore 0 in the first cycle after reset release and 1 from the second cycle.
- Upstream accept: acc = s_aw.awvalid & s_aw.awready. Downstream send: snd = m_aw.awvalid & m_aw.awready.
- Data path, per cycle:
  - out empty, acc → out <= s_aw payload.
  - out full, snd, skid empty, acc → out <= s_aw payload.
  - out full, snd, skid full → out <= skid, skid empties. No acc is possible here because ready was 0.
  - out full, !snd, acc → skid <= s_aw payload.
  - out full, snd, skid empty, !acc → out empties.
- Latency: 1 cycle from upstream handshake to m_aw.awvalid. Order is strict FIFO.
- m_aw.awvalid, once high, stays high with a stable payload until snd; it is never gated by credits.
- Credit counter:
  - count_next = count + acc - dec, where dec = b_hs_i & (count != 0).
  - acc and dec in the same cycle leave count unchanged.
  - b_hs_i with count == 0 sets underflow_o, and count stays 0. Only reset clears underflow_o.
  - The counter never exceeds MAX_OUTSTANDING, because ready is deasserted at the limit.
  - At count == MAX with a same-cycle b_hs_i, ready returns in the next cycle.
- outstanding_o = count. idle_o = !out_valid & !skid_valid & (count == 0), registered-derived.
- Reset mid-burst: all buffered AWs are dropped and the count clears. The system is responsible for resetting the downstream side together with this block.

Decomposition:
- The prv664 bus package gains typedef axi_aw_payload_t, a packed struct of the AW payload fields sized by BUS_ID_W and PADDR.
- The package also gains pack/unpack helper functions for that struct.
- Sub-module axi_skid_buffer: generic two-entry skid buffer parameterised by payload type, carrying the valid/ready plus an external accept-enable input (the credit gate). It is reused later for the AR channel.
- The credit counter, underflow flag and idle logic stay in axi_aw_credit_slice.

Test Plan:
- Reset release, m_aw.awready held 1, 8 back-to-back AWs (awid 0..7, awaddr 0x1000+0x40*i), b_hs_i pulsed 1 cycle after each send → 8 sends in 8 consecutive cycles after a 1-cycle latency, fields bit-exact, outstanding_o ≤ 2.
- MAX_OUTSTANDING=4, no b_hs_i, 6 AWs offered → exactly 4 accepted, s_aw.awready=0 with outstanding_o=4. One b_hs_i pulse → ready=1 the next cycle, 5th accepted, outstanding_o returns to 4.
- m_aw.awready low for 5 cycles with awid=3 then awid=4 offered → skid fills, s_aw.awready=0, awid=3 held stable on m_aw. On ready high: 3 sends, then 4 sends, then ready reasserts.
- outstanding_o=2, acc and b_hs_i in the same cycle → outstanding_o stays 2. b_hs_i alone → 1.
- Idle state, b_hs_i pulse → underflow_o=1 and stays 1, outstanding_o stays 0. Asserting arst_n low clears it.
- arst_n low for 1 cycle with 2 AWs buffered and outstanding_o=3 → m_aw.awvalid=0 immediately, outstanding_o=0, idle_o=1, s_aw.awready=0, then 1 the second cycle after release.
